// File: rtl/image_feeder_if.sv
// Bundle of the image_feeder control, memory and downstream signals.
// master = the feeder itself, slave = the environment (controller, memory, conv_pool).
interface image_feeder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [7:0]        interval;
   logic              stall;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] image_4x4;
   logic              input_re;
   logic [ADDR_W-1:0] input_addr;
   logic              busy;
   logic              done;

   modport master (
      input  start, base_addr, end_addr, interval, stall, mem_rdata,
      output mem_re, mem_addr, image_4x4, input_re, input_addr, busy, done
   );

   modport slave (
      output start, base_addr, end_addr, interval, stall, mem_rdata,
      input  mem_re, mem_addr, image_4x4, input_re, input_addr, busy, done
   );
endinterface

// File: rtl/image_feeder.sv
// Streams a range of 4x4 pixel blocks from image memory to the conv_pool at a fixed read pace.
// Optional macro FEEDER_CONTINUOUS_EN: loop back to base_addr forever instead of ending the frame.
module image_feeder #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 128
) (
   input  logic          clk,
   input  logic          rst,
   image_feeder_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_end;
`ifdef FEEDER_CONTINUOUS_EN
   logic [ADDR_W-1:0] r_base;
`endif
   logic [7:0]        r_wait_load;
   logic [7:0]        r_cnt;
   logic              r_re_d1;
   logic [ADDR_W-1:0] r_addr_d1;
   logic [DATA_W-1:0] r_image;
   logic              r_input_re;
   logic [ADDR_W-1:0] r_input_addr;
   logic              r_done;

   logic              w_mem_re;
   logic [ADDR_W-1:0] w_mem_addr;
   logic              w_busy;
   logic              w_last;
   logic              w_cnt_zero;
   logic              w_start_ok;

   assign w_last     = (r_addr == r_end);
   assign w_cnt_zero = (r_cnt == 8'd0);
   // A start landing on the done cycle belongs to the finished frame and is dropped.
   assign w_start_ok = (r_state == S_IDLE) && bus.start && !r_done;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) w_state_next = S_ISSUE;
         end
         S_ISSUE: begin
`ifdef FEEDER_CONTINUOUS_EN
            w_state_next = S_WAIT;
`else
            w_state_next = w_last ? S_DRAIN : S_WAIT;
`endif
         end
         S_WAIT: begin
            if (w_cnt_zero && !bus.stall) w_state_next = S_ISSUE;
         end
         S_DRAIN: begin
            if (r_input_re) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_mem_re   = (r_state == S_ISSUE);
      w_mem_addr = (r_state == S_ISSUE) ? r_addr : '0;
      w_busy     = (r_state != S_IDLE);
   end

   // Address and pacing: ISSUE plus (interval-2) counted WAIT cycles plus one expiry cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr      <= '0;
         r_end       <= '0;
`ifdef FEEDER_CONTINUOUS_EN
         r_base      <= '0;
`endif
         r_wait_load <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_start_ok) begin
            r_addr      <= bus.base_addr;
            r_end       <= bus.end_addr;
`ifdef FEEDER_CONTINUOUS_EN
            r_base      <= bus.base_addr;
`endif
            r_wait_load <= (bus.interval < 8'd2) ? 8'd0 : bus.interval - 8'd2;
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= r_wait_load;
`ifdef FEEDER_CONTINUOUS_EN
            r_addr <= w_last ? r_base : r_addr + 1'b1;
`else
            if (!w_last) r_addr <= r_addr + 1'b1;
`endif
         end else if ((r_state == S_WAIT) && !w_cnt_zero) begin
            r_cnt <= r_cnt - 8'd1;
         end
      end
   end

   // Read pipeline: memory answers one cycle after mem_re, block is presented the cycle after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_re_d1      <= 1'b0;
         r_addr_d1    <= '0;
         r_input_re   <= 1'b0;
         r_image      <= '0;
         r_input_addr <= '0;
         r_done       <= 1'b0;
      end else begin
         r_re_d1    <= w_mem_re;
         r_addr_d1  <= w_mem_addr;
         r_input_re <= r_re_d1;
         if (r_re_d1) begin
            r_image      <= bus.mem_rdata;
            r_input_addr <= r_addr_d1;
         end
`ifdef FEEDER_CONTINUOUS_EN
         r_done <= r_re_d1 && (r_addr_d1 == r_end);
`else
         r_done <= (r_state == S_DRAIN) && r_input_re;
`endif
      end
   end

   assign bus.mem_re     = w_mem_re;
   assign bus.mem_addr   = w_mem_addr;
   assign bus.image_4x4  = r_image;
   assign bus.input_re   = r_input_re;
   assign bus.input_addr = r_input_addr;
   assign bus.busy       = w_busy;
   assign bus.done       = r_done;
endmodule

// File: tb/tb_image_feeder.sv
// Directed bench for image_feeder: frame timing, address wrap, pacing, stall and mid-frame reset.
module tb_image_feeder;
   logic clk;
   logic rst;
   int   cyc;
   int   vectors;
   int   miscompares;

   image_feeder_if #(.ADDR_W(16), .DATA_W(128)) bus ();

   image_feeder #(.ADDR_W(16), .DATA_W(128)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] pat(input logic [15:0] a);
      return {4{a, a ^ 16'hA5C3}};
   endfunction

   // Image memory with a registered read port.
   always @(posedge clk) begin
      if (bus.mem_re) bus.mem_rdata <= pat(bus.mem_addr);
   end

   int             re_cyc[$];
   logic [15:0]    re_addr[$];
   int             in_cyc[$];
   logic [15:0]    in_addr[$];
   logic [127:0]   in_data[$];
   int             done_cyc[$];
   int             exp_re[$];

   always @(negedge clk) begin
      if (bus.mem_re) begin
         re_cyc.push_back(cyc);
         re_addr.push_back(bus.mem_addr);
      end
      if (bus.input_re) begin
         in_cyc.push_back(cyc);
         in_addr.push_back(bus.input_addr);
         in_data.push_back(bus.image_4x4);
      end
      if (bus.done) done_cyc.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      re_cyc.delete();
      re_addr.delete();
      in_cyc.delete();
      in_addr.delete();
      in_data.delete();
      done_cyc.delete();
      exp_re.delete();
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_mem_re"}, bus.mem_re, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_image"}, bus.image_4x4, 0);
      chk({tag, "_input_re"}, bus.input_re, 0);
      chk({tag, "_input_addr"}, bus.input_addr, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
   endtask

   // Pulses start for one cycle, then scrambles the frame parameters to show they were latched.
   task automatic start_frame(input logic [15:0] b, input logic [15:0] e, input logic [7:0] iv,
                              output int c);
      bus.base_addr = b;
      bus.end_addr  = e;
      bus.interval  = iv;
      bus.start     = 1'b1;
      c = cyc;
      tick();
      bus.start     = 1'b0;
      bus.base_addr = 16'hDEAD;
      bus.end_addr  = 16'hBEEF;
      bus.interval  = 8'd1;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 3000 && done_cyc.size() == 0; i++) tick();
      chk({tag, "_done_seen"}, done_cyc.size() != 0, 1);
      repeat (6) tick();
   endtask

   task automatic check_frame(input string tag, input logic [15:0] a0);
      int n;
      n = exp_re.size();
      chk({tag, "_n_mem_re"}, re_cyc.size(), n);
      chk({tag, "_n_input_re"}, in_cyc.size(), n);
      for (int i = 0; i < n; i++) begin
         logic [15:0] a;
         a = a0 + 16'(i);
         if (i < re_cyc.size()) begin
            chk($sformatf("%s_re_t%0d", tag, i), re_cyc[i], exp_re[i]);
            chk($sformatf("%s_re_a%0d", tag, i), re_addr[i], a);
         end
         if (i < in_cyc.size()) begin
            chk($sformatf("%s_in_t%0d", tag, i), in_cyc[i], exp_re[i] + 2);
            chk($sformatf("%s_in_a%0d", tag, i), in_addr[i], a);
            chk($sformatf("%s_in_d%0d", tag, i), in_data[i], pat(a));
         end
      end
      chk({tag, "_n_done"}, done_cyc.size(), 1);
      if (done_cyc.size() != 0) chk({tag, "_done_t"}, done_cyc[0], exp_re[n-1] + 3);
   endtask

   initial begin
      int c;
      vectors       = 0;
      miscompares   = 0;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.end_addr  = '0;
      bus.interval  = '0;
      bus.stall     = 1'b0;
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b1;
      repeat (2) tick();

      // Four blocks at interval 38: reads at T, T+38, T+76, T+114, done at T+117.
      clr();
      start_frame(16'h0000, 16'h0003, 8'd38, c);
      chk("t1_busy", bus.busy, 1);
      wait_done("t1");
      exp_re = '{c+1, c+39, c+77, c+115};
      check_frame("t1", 16'h0000);
      chk("t1_busy_after", bus.busy, 0);

      // Single block, plus a start coinciding with done that must be ignored.
      clr();
      start_frame(16'h0010, 16'h0010, 8'd5, c);
      repeat (3) tick();
      chk("t2_done_now", bus.done, 1);
      bus.base_addr = 16'h0010;
      bus.end_addr  = 16'h0010;
      bus.interval  = 8'd5;
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
      chk("t2_busy_after", bus.busy, 0);
      chk("t2_done_cleared", bus.done, 0);
      repeat (6) tick();
      exp_re = '{c+1};
      check_frame("t2", 16'h0010);

      // interval 0 behaves as 2.
      clr();
      start_frame(16'h0000, 16'h0007, 8'd0, c);
      wait_done("t3");
      for (int i = 0; i < 8; i++) exp_re.push_back(c + 1 + 2*i);
      check_frame("t3", 16'h0000);

      // Address wrap through FFFF.
      clr();
      start_frame(16'hFFFE, 16'h0001, 8'd3, c);
      wait_done("t4");
      exp_re = '{c+1, c+4, c+7, c+10};
      check_frame("t4", 16'hFFFE);

      // Stall high T+1..T+10 spans the in-flight read and the WAIT expiry at T+3.
      clr();
      start_frame(16'h0020, 16'h0022, 8'd4, c);
      tick();
      bus.stall = 1'b1;
      repeat (10) tick();
      bus.stall = 1'b0;
      wait_done("t5");
      exp_re = '{c+1, c+13, c+17};
      check_frame("t5", 16'h0020);

      // Reset one cycle after the 2nd read, while that read is still in flight.
      clr();
      start_frame(16'h0040, 16'h0047, 8'd6, c);
      repeat (7) tick();
      chk("t6_pre_n_re", re_cyc.size(), 2);
      chk("t6_pre_image", bus.image_4x4, pat(16'h0040));
      rst = 1'b0;
      #1;
      check_idle("t6_rst");
      repeat (3) tick();
      rst = 1'b1;
      clr();
      repeat (20) tick();
      chk("t6_post_n_re", re_cyc.size(), 0);
      chk("t6_post_n_in", in_cyc.size(), 0);
      chk("t6_post_n_done", done_cyc.size(), 0);
      start_frame(16'h0050, 16'h0051, 8'd2, c);
      wait_done("t6b");
      exp_re = '{c+1, c+3};
      check_frame("t6b", 16'h0050);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
